// File: rtl/ysyx_23060201_isram_if.sv
// Fetch read channel between the instruction fetch unit (master) and the isram responder (slave).
// Handshake: a beat transfers on a rising edge where valid and ready are both 1; once valid is
// raised, the sender keeps valid and its payload stable until that edge.
interface ysyx_23060201_isram_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;

  modport master (
    output arvalid, araddr, rready,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    input  arvalid, araddr, rready,
    output arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/ysyx_23060201_isram.sv
// Instruction-memory read responder: accepts one fetch address, waits a programmable (optionally
// pseudo-random) delay, then returns the memory word or an error response.
module ysyx_23060201_isram #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = 32'h8000_0000,
  parameter logic [ADDR_WIDTH-1:0] MEM_SIZE   = 32'h0800_0000,
  parameter int                    LATENCY    = 1,
  parameter int                    RAND_DELAY = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  ysyx_23060201_isram_if.slave  bus,
  output logic                  pmem_ren,
  output logic [ADDR_WIDTH-1:0] pmem_addr,
  input  logic [DATA_WIDTH-1:0] pmem_rdata,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  // One extra bit so MEM_BASE + MEM_SIZE cannot wrap at the top of the address space.
  localparam logic [ADDR_WIDTH:0] BASE_X = {1'b0, MEM_BASE};
  localparam logic [ADDR_WIDTH:0] END_X  = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};

  state_e                state_q, state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [7:0]            lfsr_q, lfsr_d;

  logic [7:0]            extra_delay;
  logic [ADDR_WIDTH:0]   addr_x;
  logic                  misaligned;
  logic                  out_of_range;

  // x^8 + x^6 + x^5 + x^4 + 1, shifting toward the MSB.
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_comb begin
    extra_delay = 8'd0;
    if (RAND_DELAY != 0) begin
      extra_delay = {6'd0, lfsr_q[1:0]};
    end
  end

  always_comb begin
    addr_x       = {1'b0, addr_q};
    misaligned   = (addr_q[1:0] != 2'b00);
    out_of_range = (addr_x < BASE_X) || (addr_x >= END_X);
  end

  always_comb begin
    state_d   = state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    pmem_ren  = 1'b0;

    case (state_q)
      S_IDLE: begin
        arready_d = 1'b1;
        rvalid_d  = 1'b0;
        if (bus.arvalid && arready_q) begin
          addr_d    = bus.araddr;
          cnt_d     = LAT_M1 + extra_delay;
          arready_d = 1'b0;
          state_d   = S_WAIT;
        end
      end

      S_WAIT: begin
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
        if (cnt_q == 8'd0) begin
          if (misaligned) begin
            rresp_d = RESP_SLVERR;
            rdata_d = '0;
          end else if (out_of_range) begin
            rresp_d = RESP_DECERR;
            rdata_d = '0;
          end else begin
            // Memory is read only when the edge will not be a reset edge.
            pmem_ren = !rst;
            rresp_d  = RESP_OKAY;
            rdata_d  = pmem_rdata;
          end
          rvalid_d = 1'b1;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      S_RESP: begin
        arready_d = 1'b0;
        rvalid_d  = 1'b1;
        if (bus.rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          state_d   = S_IDLE;
        end
      end

      default: begin
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      addr_q    <= '0;
      cnt_q     <= 8'd0;
      lfsr_q    <= 8'hA5;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
    end
  end

  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign pmem_addr   = addr_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ysyx_23060201_isram.sv
// Directed bench for the isram responder: four instances cover latency 1, 3, 4 and randomised
// latency 2..5; a small word array stands in for physical memory and counts every read.
module tb_ysyx_23060201_isram;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clk;
  logic rst_a, rst_b, rst_c, rst_d;
  int   checks = 0;
  int   failures = 0;
  int   rd_a = 0, rd_b = 0, rd_c = 0, rd_d = 0;

  logic [31:0] mem [0:255];
  logic [31:0] exp_q[$];
  int          gap_q[$];

  logic        pmem_ren_a, pmem_ren_b, pmem_ren_c, pmem_ren_d;
  logic [31:0] pmem_addr_a, pmem_addr_b, pmem_addr_c, pmem_addr_d;
  logic [31:0] pmem_rdata_a, pmem_rdata_b, pmem_rdata_c, pmem_rdata_d;
  logic [1:0]  dbg_a, dbg_b, dbg_c, dbg_d;

  ysyx_23060201_isram_if if_a ();
  ysyx_23060201_isram_if if_b ();
  ysyx_23060201_isram_if if_c ();
  ysyx_23060201_isram_if if_d ();

  assign pmem_rdata_a = mem[pmem_addr_a[9:2]];
  assign pmem_rdata_b = mem[pmem_addr_b[9:2]];
  assign pmem_rdata_c = mem[pmem_addr_c[9:2]];
  assign pmem_rdata_d = mem[pmem_addr_d[9:2]];

  ysyx_23060201_isram #(.LATENCY(1), .RAND_DELAY(0)) u_a (
    .clk(clk), .rst(rst_a), .bus(if_a.slave), .pmem_ren(pmem_ren_a),
    .pmem_addr(pmem_addr_a), .pmem_rdata(pmem_rdata_a), .dbg_state(dbg_a));
  ysyx_23060201_isram #(.LATENCY(3), .RAND_DELAY(0)) u_b (
    .clk(clk), .rst(rst_b), .bus(if_b.slave), .pmem_ren(pmem_ren_b),
    .pmem_addr(pmem_addr_b), .pmem_rdata(pmem_rdata_b), .dbg_state(dbg_b));
  ysyx_23060201_isram #(.LATENCY(2), .RAND_DELAY(1)) u_c (
    .clk(clk), .rst(rst_c), .bus(if_c.slave), .pmem_ren(pmem_ren_c),
    .pmem_addr(pmem_addr_c), .pmem_rdata(pmem_rdata_c), .dbg_state(dbg_c));
  ysyx_23060201_isram #(.LATENCY(4), .RAND_DELAY(0)) u_d (
    .clk(clk), .rst(rst_d), .bus(if_d.slave), .pmem_ren(pmem_ren_d),
    .pmem_addr(pmem_addr_d), .pmem_rdata(pmem_rdata_d), .dbg_state(dbg_d));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pmem_ren_a) rd_a <= rd_a + 1;
    if (pmem_ren_b) rd_b <= rd_b + 1;
    if (pmem_ren_c) rd_c <= rd_c + 1;
    if (pmem_ren_d) rd_d <= rd_d + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // Word i of memory: an addi x1,x0,i encoding, except word 0 which holds 0x0000_0413.
  function automatic logic [31:0] exp_word(input int i);
    logic [31:0] w;
    if (i == 0) w = 32'h0000_0413;
    else        w = 32'h0000_0093 | (32'(i) << 20);
    return w;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_read_a(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output int lat, output bit ok);
    bit acc;
    int acc_edge;
    acc_edge = -1; ok = 0; lat = 0; data = '0; resp = '0;
    if_a.arvalid = 1'b1; if_a.araddr = addr; if_a.rready = 1'b1;
    for (int cyc = 0; cyc < 50 && !ok; cyc++) begin
      acc = if_a.arvalid && if_a.arready;
      @(posedge clk); #1;
      if (acc) begin if_a.arvalid = 1'b0; acc_edge = cyc + 1; end
      if (if_a.rvalid) begin
        data = if_a.rdata; resp = if_a.rresp; lat = cyc + 1 - acc_edge; ok = 1;
      end
    end
    @(posedge clk); #1;
    if_a.arvalid = 1'b0; if_a.rready = 1'b0;
  endtask

  task automatic do_read_d(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output int lat, output bit ok);
    bit acc;
    int acc_edge;
    acc_edge = -1; ok = 0; lat = 0; data = '0; resp = '0;
    if_d.arvalid = 1'b1; if_d.araddr = addr; if_d.rready = 1'b1;
    for (int cyc = 0; cyc < 50 && !ok; cyc++) begin
      acc = if_d.arvalid && if_d.arready;
      @(posedge clk); #1;
      if (acc) begin if_d.arvalid = 1'b0; acc_edge = cyc + 1; end
      if (if_d.rvalid) begin
        data = if_d.rdata; resp = if_d.rresp; lat = cyc + 1 - acc_edge; ok = 1;
      end
    end
    @(posedge clk); #1;
    if_d.arvalid = 1'b0; if_d.rready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (if_a.arready !== 1'b0) begin failures++; $display("FAIL reset_arready got=%b want=0", if_a.arready); end
    checks++; if (if_a.rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b want=0", if_a.rvalid); end
    checks++; if (if_a.rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h want=0", if_a.rdata); end
    checks++; if (if_a.rresp !== 2'b00) begin failures++; $display("FAIL reset_rresp got=%b want=00", if_a.rresp); end
    checks++; if (dbg_a !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d want=0", dbg_a); end
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
    @(posedge clk); #1;
    checks++; if (if_a.arready !== 1'b1) begin failures++; $display("FAIL reset_release_arready_a got=%b want=1", if_a.arready); end
    checks++; if (if_b.arready !== 1'b1) begin failures++; $display("FAIL reset_release_arready_b got=%b want=1", if_b.arready); end
  endtask

  task automatic test_single();
    int rd0;
    rd0 = rd_a;
    if_a.araddr = BASE; if_a.arvalid = 1'b1; if_a.rready = 1'b0;
    @(posedge clk); #1;
    if_a.arvalid = 1'b0;
    checks++; if (if_a.rvalid !== 1'b0) begin failures++; $display("FAIL single_accept_rvalid got=%b want=0", if_a.rvalid); end
    checks++; if (dbg_a !== 2'd1) begin failures++; $display("FAIL single_wait_state got=%0d want=1", dbg_a); end
    @(posedge clk); #1;
    checks++; if (if_a.rvalid !== 1'b1) begin failures++; $display("FAIL single_rvalid got=%b want=1", if_a.rvalid); end
    checks++; if (if_a.rdata !== 32'h0000_0413) begin failures++; $display("FAIL single_rdata got=%h want=00000413", if_a.rdata); end
    checks++; if (if_a.rresp !== 2'b00) begin failures++; $display("FAIL single_rresp got=%b want=00", if_a.rresp); end
    checks++; if (if_a.arready !== 1'b0) begin failures++; $display("FAIL single_resp_arready got=%b want=0", if_a.arready); end
    if_a.rready = 1'b1;
    @(posedge clk); #1;
    if_a.rready = 1'b0;
    checks++; if (if_a.rvalid !== 1'b0) begin failures++; $display("FAIL single_after_rvalid got=%b want=0", if_a.rvalid); end
    checks++; if (if_a.arready !== 1'b1) begin failures++; $display("FAIL single_after_arready got=%b want=1", if_a.arready); end
    checks++; if (rd_a - rd0 !== 1) begin failures++; $display("FAIL single_reads got=%0d want=1", rd_a - rd0); end
  endtask

  task automatic test_backpressure();
    int rd0;
    rd0 = rd_b;
    if_b.araddr = BASE + 32'h8; if_b.arvalid = 1'b1; if_b.rready = 1'b0;
    @(posedge clk); #1;
    if_b.arvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (if_b.rvalid !== 1'b0) begin failures++; $display("FAIL bp_wait_rvalid k=%0d got=%b want=0", k, if_b.rvalid); end
      if (k < 2) begin @(posedge clk); #1; end
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++; if (if_b.rvalid !== 1'b1) begin failures++; $display("FAIL bp_rvalid k=%0d got=%b want=1", k, if_b.rvalid); end
      checks++; if (if_b.rdata !== 32'h0020_0093) begin failures++; $display("FAIL bp_rdata k=%0d got=%h want=00200093", k, if_b.rdata); end
      checks++; if (if_b.rresp !== 2'b00) begin failures++; $display("FAIL bp_rresp k=%0d got=%b want=00", k, if_b.rresp); end
      checks++; if (if_b.arready !== 1'b0) begin failures++; $display("FAIL bp_arready k=%0d got=%b want=0", k, if_b.arready); end
      checks++; if (dbg_b !== 2'd2) begin failures++; $display("FAIL bp_state k=%0d got=%0d want=2", k, dbg_b); end
    end
    if_b.rready = 1'b1;
    @(posedge clk); #1;
    if_b.rready = 1'b0;
    checks++; if (if_b.rvalid !== 1'b0) begin failures++; $display("FAIL bp_after_rvalid got=%b want=0", if_b.rvalid); end
    checks++; if (if_b.arready !== 1'b1) begin failures++; $display("FAIL bp_after_arready got=%b want=1", if_b.arready); end
    checks++; if (rd_b - rd0 !== 1) begin failures++; $display("FAIL bp_reads got=%0d want=1", rd_b - rd0); end
  endtask

  task automatic test_errors();
    logic [31:0] addr_t [4];
    logic [1:0]  resp_t [4];
    logic [31:0] data_t [4];
    int          inc_t  [4];
    logic [31:0] data;
    logic [1:0]  resp;
    int          lat, rd0;
    bit          ok;
    addr_t = '{32'h8000_0002, 32'h7FFF_FFFC, 32'h8800_0000, 32'h87FF_FFFC};
    resp_t = '{2'b10, 2'b11, 2'b11, 2'b00};
    data_t = '{32'h0, 32'h0, 32'h0, 32'h0FF0_0093};
    inc_t  = '{0, 0, 0, 1};
    for (int i = 0; i < 4; i++) begin
      rd0 = rd_a;
      do_read_a(addr_t[i], data, resp, lat, ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL err_timeout addr=%h got=no_response want=response", addr_t[i]); end
      checks++; if (resp !== resp_t[i]) begin failures++; $display("FAIL err_rresp addr=%h got=%b want=%b", addr_t[i], resp, resp_t[i]); end
      checks++; if (data !== data_t[i]) begin failures++; $display("FAIL err_rdata addr=%h got=%h want=%h", addr_t[i], data, data_t[i]); end
      checks++; if (lat !== 1) begin failures++; $display("FAIL err_latency addr=%h got=%0d want=1", addr_t[i], lat); end
      checks++; if (rd_a - rd0 !== inc_t[i]) begin failures++; $display("FAIL err_reads addr=%h got=%0d want=%0d", addr_t[i], rd_a - rd0, inc_t[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] data;
    logic [1:0]  resp;
    int          lat, rd0;
    bit          ok, seen;
    rd0 = rd_d; seen = 0;
    if_d.araddr = BASE + 32'h10; if_d.arvalid = 1'b1; if_d.rready = 1'b1;
    checks++; if (if_d.arready !== 1'b1) begin failures++; $display("FAIL mid_pre_arready got=%b want=1", if_d.arready); end
    @(posedge clk); #1;
    if_d.arvalid = 1'b0;
    rst_d = 1'b1;
    @(posedge clk); #1;
    checks++; if (if_d.rvalid !== 1'b0) begin failures++; $display("FAIL mid_reset_rvalid got=%b want=0", if_d.rvalid); end
    checks++; if (if_d.arready !== 1'b0) begin failures++; $display("FAIL mid_reset_arready got=%b want=0", if_d.arready); end
    checks++; if (dbg_d !== 2'd0) begin failures++; $display("FAIL mid_reset_state got=%0d want=0", dbg_d); end
    @(posedge clk); #1;
    rst_d = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (if_d.rvalid === 1'b1) seen = 1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mid_ghost_rvalid got=1 want=0"); end
    checks++; if (rd_d - rd0 !== 0) begin failures++; $display("FAIL mid_abandoned_reads got=%0d want=0", rd_d - rd0); end
    do_read_d(BASE + 32'h4, data, resp, lat, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL mid_new_timeout got=no_response want=response"); end
    checks++; if (data !== 32'h0010_0093) begin failures++; $display("FAIL mid_new_rdata got=%h want=00100093", data); end
    checks++; if (resp !== 2'b00) begin failures++; $display("FAIL mid_new_rresp got=%b want=00", resp); end
    checks++; if (lat !== 4) begin failures++; $display("FAIL mid_new_latency got=%0d want=4", lat); end
    checks++; if (rd_d - rd0 !== 1) begin failures++; $display("FAIL mid_new_reads got=%0d want=1", rd_d - rd0); end
  endtask

  task automatic test_rand_delay();
    logic [7:0]  lfsr_m;
    logic [31:0] exp_w;
    bit          acc;
    int          acc_edge, n_acc, n_resp, gap, exp_gap, rd0;
    rst_c = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_c = 1'b0;
    lfsr_m = 8'hA5;
    rd0 = rd_c; acc_edge = 0; n_acc = 0; n_resp = 0;
    exp_q.delete(); gap_q.delete();
    if_c.araddr = BASE; if_c.arvalid = 1'b1; if_c.rready = 1'b1;
    for (int cyc = 0; cyc < 1500 && n_resp < 100; cyc++) begin
      acc = if_c.arvalid && if_c.arready;
      if (acc) begin
        acc_edge = cyc + 1;
        gap_q.push_back(2 + int'(lfsr_m[1:0]));
        exp_q.push_back(exp_word(n_acc));
        n_acc++;
      end
      @(posedge clk); #1;
      lfsr_m = lfsr_step(lfsr_m);
      if (acc) begin
        if_c.araddr = BASE + 32'(n_acc) * 32'd4;
        if (n_acc == 100) if_c.arvalid = 1'b0;
      end
      if (if_c.rvalid === 1'b1) begin
        gap = cyc + 1 - acc_edge;
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        exp_gap = (gap_q.size() > 0) ? gap_q.pop_front() : -1;
        checks++; if (if_c.rdata !== exp_w) begin failures++; $display("FAIL rand_rdata n=%0d got=%h want=%h", n_resp, if_c.rdata, exp_w); end
        checks++; if (if_c.rresp !== 2'b00) begin failures++; $display("FAIL rand_rresp n=%0d got=%b want=00", n_resp, if_c.rresp); end
        checks++; if (gap !== exp_gap) begin failures++; $display("FAIL rand_gap n=%0d got=%0d want=%0d", n_resp, gap, exp_gap); end
        checks++; if (gap < 2 || gap > 5) begin failures++; $display("FAIL rand_gap_range n=%0d got=%0d want=2..5", n_resp, gap); end
        checks++; if (dbg_c !== 2'd2) begin failures++; $display("FAIL rand_state n=%0d got=%0d want=2", n_resp, dbg_c); end
        n_resp++;
      end
    end
    @(posedge clk); #1;
    if_c.arvalid = 1'b0; if_c.rready = 1'b0;
    checks++; if (n_resp !== 100) begin failures++; $display("FAIL rand_count got=%0d want=100", n_resp); end
    checks++; if (rd_c - rd0 !== 100) begin failures++; $display("FAIL rand_reads got=%0d want=100", rd_c - rd0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w;
    bit          acc;
    int          n_acc, n_resp, last_rv;
    n_acc = 0; n_resp = 0; last_rv = -1;
    exp_q.delete();
    if_a.araddr = BASE + 32'h40; if_a.arvalid = 1'b1; if_a.rready = 1'b1;
    for (int cyc = 0; cyc < 100 && n_resp < 6; cyc++) begin
      acc = if_a.arvalid && if_a.arready;
      if (acc) begin
        exp_q.push_back(exp_word(16 + n_acc));
        n_acc++;
      end
      @(posedge clk); #1;
      if (acc) begin
        if_a.araddr = BASE + 32'h40 + 32'(n_acc) * 32'd4;
        if (n_acc == 6) if_a.arvalid = 1'b0;
      end
      if (if_a.rvalid === 1'b1) begin
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        checks++; if (if_a.rdata !== exp_w) begin failures++; $display("FAIL b2b_rdata n=%0d got=%h want=%h", n_resp, if_a.rdata, exp_w); end
        checks++; if (if_a.rresp !== 2'b00) begin failures++; $display("FAIL b2b_rresp n=%0d got=%b want=00", n_resp, if_a.rresp); end
        if (last_rv >= 0) begin
          checks++; if (cyc - last_rv !== 3) begin failures++; $display("FAIL b2b_period n=%0d got=%0d want=3", n_resp, cyc - last_rv); end
        end
        last_rv = cyc;
        n_resp++;
      end
    end
    @(posedge clk); #1;
    if_a.arvalid = 1'b0; if_a.rready = 1'b0;
    checks++; if (n_resp !== 6) begin failures++; $display("FAIL b2b_count got=%0d want=6", n_resp); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = exp_word(i);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
    if_a.arvalid = 1'b0; if_a.araddr = '0; if_a.rready = 1'b0;
    if_b.arvalid = 1'b0; if_b.araddr = '0; if_b.rready = 1'b0;
    if_c.arvalid = 1'b0; if_c.araddr = '0; if_c.rready = 1'b0;
    if_d.arvalid = 1'b0; if_d.araddr = '0; if_d.rready = 1'b0;

    test_reset();
    test_single();
    test_backpressure();
    test_errors();
    test_reset_mid();
    test_rand_delay();
    test_back_to_back();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_23060201_isram.md
# ysyx_23060201_isram

Instruction-memory read responder: the slave end of the fetch interface. Accepts one read address per transaction over a valid/ready address channel. After a programmable delay it returns the 32-bit word from simulated physical memory (DPI `pmem_read`) on a valid/ready data channel. It sits between the fetch unit and the memory model and replaces the zero-latency direct DPI read, so the pipeline front end can be exercised against realistic, variable memory latency.

## Interface
- `ADDR_WIDTH`, 32, read address width
- `DATA_WIDTH`, 32, read data width
- `MEM_BASE`, 32'h8000_0000, first valid byte address
- `MEM_SIZE`, 32'h0800_0000, size of the valid region in bytes
- `LATENCY`, 1, base cycles from address accept to `rvalid`; legal range 1..200
- `RAND_DELAY`, 0, when 1 adds 0..3 pseudo-random extra cycles per transaction

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `arvalid`  in  1  fetch presents a read address
- `arready`  out  1  responder can accept an address
- `araddr`  in  ADDR_WIDTH  byte address of the instruction
- `rvalid`  out  1  read data/response valid
- `rready`  in  1  fetch accepts read data
- `rdata`  out  DATA_WIDTH  instruction word
- `rresp`  out  2  2'b00 OKAY, 2'b10 SLVERR (misaligned), 2'b11 DECERR (out of range)

## Operation
- FSM states: IDLE, WAIT, RESP. One outstanding transaction, no ordering queue.
- IDLE:
  - `arready`=1.
  - On `arvalid && arready`, latch `araddr` and load `cnt` = delay-1. Delay = `LATENCY`, plus `lfsr[1:0]` when `RAND_DELAY`=1.
  - Go to WAIT.
- WAIT:
  - `arready`=0, `rvalid`=0.
  - If `cnt`==0: evaluate the latched address, register `rdata`/`rresp`, go to RESP.
  - Otherwise decrement `cnt`.
- Address evaluation, in priority order:
  - Misaligned (`addr[1:0]`!=0): `rresp`=2'b10, `rdata`=0, no DPI call.
  - Out of range (`addr < MEM_BASE` or `addr >= MEM_BASE+MEM_SIZE`, compared as unsigned 33-bit to avoid wrap): `rresp`=2'b11, `rdata`=0, no DPI call.
  - Otherwise: `rdata`=`pmem_read(addr)`, `rresp`=2'b00.
  - Exactly one DPI call per successful transaction.
- RESP:
  - `rvalid`=1. `rdata` and `rresp` are held stable until `rvalid && rready`.
  - On that handshake go to IDLE and clear `rvalid`.
- `cnt`: 8 bits, saturating (never underflows).
- `lfsr`: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, seed 8'hA5. Advances every non-reset cycle, independent of FSM state.
- Inputs `araddr` and `arvalid` are ignored outside IDLE. `rready` is ignored outside RESP.

## Timing
- Reset values while `rst`=1: state IDLE, `arready`=0, `rvalid`=0, `rdata`=0, `rresp`=2'b00, `cnt`=0, `lfsr`=8'hA5.
- `arready` is registered: it reads 1 in the first cycle after `rst` deasserts.
- Address accepted at edge N → `rvalid`=1 after edge N+delay. With `LATENCY`=1 and `RAND_DELAY`=0, data is visible one cycle after accept.
- Response handshake at edge M → `rvalid`=0 and `arready`=1 after edge M. The earliest next accept is edge M+1, so peak throughput is one word per delay+2 cycles.
- `rready` held low in RESP: hold indefinitely; no timeout, no data change.
- `rready` already high when `rvalid` rises: handshake completes on the first RESP edge (one-cycle RESP).
- Reset asserted in WAIT or RESP:
  - The transaction is abandoned with no response, and all outputs take their reset values at that edge.
  - A pending DPI read is not performed.
- `arvalid` held high continuously: a new transaction is accepted each time IDLE is re-entered.

## Test plan
- Reset then single read: `LATENCY`=1, memory[0x8000_0000]=0x0000_0413, `araddr`=0x8000_0000 → `rvalid` one cycle after accept, `rdata`=0x0000_0413, `rresp`=00.
- Backpressure: `LATENCY`=3, `rready`=0 for 5 cycles after `rvalid` → `rvalid`, `rdata` and `rresp` stable throughout; `arready`=0 until one cycle after handshake.
- Errors:
  - `araddr`=0x8000_0002 → `rresp`=10, `rdata`=0.
  - `araddr`=0x7FFF_FFFC → `rresp`=11.
  - `araddr`=0x8800_0000 → `rresp`=11.
  - No DPI call counted in any of these cases.
- Random delay: `RAND_DELAY`=1, `LATENCY`=2, 100 sequential reads at pc, pc+4, ... → every accept-to-`rvalid` gap lies in 2..5, data matches memory in order, and gap sequence matches the LFSR reference model from seed 0xA5.
- Reset mid-transaction: assert `rst` one cycle after accept with `LATENCY`=4 → no `rvalid` ever asserted for that address; after release, a new read at 0x8000_0004 returns the correct word.
- Back-to-back: `arvalid` tied high, `rready` tied high, `LATENCY`=1 → one response every 3 cycles; addresses are served in order.
